// File: rtl/common_dffram_fifo_ctrl_if.sv
// Purpose : bundles the push/pop handshakes, status outputs and the RAM ports of the FIFO controller.
// Latency : n/a (signal bundle only).
// Backpressure: n/a (signal bundle only).
//
// slave  : the FIFO controller side.
// master : the surrounding logic side (producer, consumer and the DFF RAM).
interface common_dffram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic                  ram_ena;
    logic [DATA_WIDTH-1:0] ram_wea;
    logic [DATA_WIDTH-1:0] ram_dina;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0] ram_doutb;

    modport slave (
        input  flush, in_valid, in_data, out_ready, ram_doutb,
        output in_ready, out_valid, out_data, count, almost_full,
               ram_addra, ram_ena, ram_wea, ram_dina, ram_addrb
    );

    modport master (
        output flush, in_valid, in_data, out_ready, ram_doutb,
        input  in_ready, out_valid, out_data, count, almost_full,
               ram_addra, ram_ena, ram_wea, ram_dina, ram_addrb
    );
endinterface

// File: rtl/common_dffram_fifo_ctrl.sv
// Purpose : FWFT valid/ready FIFO controller driving an external DFF simple dual-port RAM.
// Latency : a push in cycle N shows on out_valid/out_data in cycle N+1 (no same-cycle bypass).
// Backpressure: in_ready = !full and never depends on out_ready; a full FIFO frees a slot one cycle after a pop.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous reset, active low
//   io     - handshakes (in_*/out_*), flush, count, almost_full and the RAM
//            write port (ram_addra/ena/wea/dina) and read port (ram_addrb/doutb)
module common_dffram_fifo_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 2,
    parameter int AFULL_THRESHOLD = (1 << ADDR_WIDTH) - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    common_dffram_fifo_ctrl_if.slave io
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_TH = (ADDR_WIDTH + 1)'(AFULL_THRESHOLD);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wptr_q;
    logic [ADDR_WIDTH:0] rptr_q;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_d;
    logic                afull_q;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);

    // Gating with reset keeps the RAM write port idle while reset is held,
    // even though in_ready reads 1 then.
    assign push = io.in_valid  & ~full  & ~io.flush & reset;
    assign pop  = io.out_ready & ~empty & ~io.flush & reset;

    always_comb begin
        count_d = count_q;
        if (io.flush) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            afull_q <= 1'b0;
        end else begin
            if (io.flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_ONE;
                if (pop)  rptr_q <= rptr_q + PTR_ONE;
            end
            count_q <= count_d;
            // Threshold is at least 1, so a flush (count_d = 0) always clears this.
            afull_q <= (count_d >= AFULL_TH);
        end
    end

    assign io.in_ready    = ~full;
    assign io.out_valid   = ~empty;
    assign io.out_data    = io.ram_doutb;
    assign io.count       = count_q;
    assign io.almost_full = afull_q;

    // The write never aliases the head entry: when not full, wptr's slot is free.
    assign io.ram_ena   = push;
    assign io.ram_addra = wptr_q[ADDR_WIDTH-1:0];
    assign io.ram_wea   = {DATA_WIDTH{push}};
    assign io.ram_dina  = io.in_data;
    assign io.ram_addrb = rptr_q[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Purpose : self-checking bench for common_dffram_fifo_ctrl with a behavioural DFF RAM.
// Latency : inputs are driven 1 time unit after a rising edge and sampled 1 unit later.
// Backpressure: exercised by the full-FIFO, simultaneous push/pop, flush and reset sequences.
module tb_common_dffram_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    common_dffram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    common_dffram_fifo_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .AFULL_THRESHOLD(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    // Behavioural DFF RAM: synchronous bit-masked write, combinational read.
    logic [DW-1:0] mem [4];
    always_ff @(posedge clk) begin
        if (bus.ram_ena)
            mem[bus.ram_addra] <= (mem[bus.ram_addra] & ~bus.ram_wea) | (bus.ram_dina & bus.ram_wea);
    end
    assign bus.ram_doutb = mem[bus.ram_addrb];

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          fl;
        logic          ir;
        logic          ov;
        logic [DW-1:0] dout;
        logic [AW:0]   cnt;
        logic          af;
        logic          ena;
        logic [AW-1:0] addra;
    } vec_t;

    vec_t vt [15];
    logic [DW-1:0] q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        //        iv    din    or    fl     ir    ov    dout   cnt   af    ena   addra
        vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 2'd0};
        vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 1'b1, 2'd1};
        vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0, 1'b1, 2'd2};
        vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1, 1'b1, 2'd3};
        vt[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0, 2'd0};
        vt[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1, 1'b1, 2'd0};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 3'd4, 1'b1, 1'b0, 2'd0};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1, 1'b0, 2'd0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 3'd2, 1'b0, 1'b0, 2'd0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0, 1'b0, 2'd0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 2'd0};
        vt[11] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 2'd1};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0, 2'd0};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0, 2'd0};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 2'd0};

        // Reset held with a push request pending: RAM port must stay idle.
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        repeat (2) tick();
        check("rst_in_ready",  32'(bus.in_ready),    32'd1);
        check("rst_out_valid", 32'(bus.out_valid),   32'd0);
        check("rst_afull",     32'(bus.almost_full), 32'd0);
        check("rst_ram_ena",   32'(bus.ram_ena),     32'd0);
        check("rst_ram_addrb", 32'(bus.ram_addrb),   32'd0);
        check("rst_count",     32'(bus.count),       32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick();

        // Fill, full-with-pop, drain, empty pop, empty push latency.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].iv, vt[i].din, vt[i].ordy, vt[i].fl);
            #1;
            check($sformatf("v%0d_in_ready", i),  32'(bus.in_ready),    32'(vt[i].ir));
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid),   32'(vt[i].ov));
            check($sformatf("v%0d_count", i),     32'(bus.count),       32'(vt[i].cnt));
            check($sformatf("v%0d_afull", i),     32'(bus.almost_full), 32'(vt[i].af));
            check($sformatf("v%0d_ram_ena", i),   32'(bus.ram_ena),     32'(vt[i].ena));
            if (vt[i].ov)
                check($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].dout));
            if (vt[i].ena) begin
                check($sformatf("v%0d_ram_addra", i), 32'(bus.ram_addra), 32'(vt[i].addra));
                check($sformatf("v%0d_ram_dina", i),  32'(bus.ram_dina),  32'(vt[i].din));
                check($sformatf("v%0d_ram_wea", i),   32'(bus.ram_wea),   32'hFF);
            end
            tick();
        end

        // Streaming: two entries held, push and pop every cycle.
        push_one(8'h60);
        push_one(8'h61);
        q.push_back(8'h60);
        q.push_back(8'h61);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h62 + i), 1'b1, 1'b0);
            #1;
            check($sformatf("s%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("s%0d_out_data", i),  32'(bus.out_data),  32'(q[0]));
            check($sformatf("s%0d_count", i),     32'(bus.count),     32'd2);
            check($sformatf("s%0d_in_ready", i),  32'(bus.in_ready),  32'd1);
            void'(q.pop_front());
            q.push_back(8'(8'h62 + i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            check($sformatf("d%0d_out_data", i), 32'(bus.out_data), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("stream_empty_count", 32'(bus.count), 32'd0);

        // Flush overriding a simultaneous push and pop.
        tick();
        push_one(8'h71);
        push_one(8'h72);
        push_one(8'h73);
        check("pre_flush_count", 32'(bus.count),       32'd3);
        check("pre_flush_afull", 32'(bus.almost_full), 32'd1);
        drive(1'b1, 8'h74, 1'b1, 1'b1);
        #1;
        check("flush_ram_ena", 32'(bus.ram_ena), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check("post_flush_count",     32'(bus.count),       32'd0);
        check("post_flush_out_valid", 32'(bus.out_valid),   32'd0);
        check("post_flush_afull",     32'(bus.almost_full), 32'd0);
        check("post_flush_in_ready",  32'(bus.in_ready),    32'd1);

        // Asynchronous reset while full.
        tick();
        push_one(8'h81);
        push_one(8'h82);
        push_one(8'h83);
        push_one(8'h84);
        drive(1'b1, 8'h85, 1'b0, 1'b0);
        #1;
        check("pre_arst_count",    32'(bus.count),    32'd4);
        check("pre_arst_in_ready", 32'(bus.in_ready), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("arst_count",     32'(bus.count),       32'd0);
        check("arst_out_valid", 32'(bus.out_valid),   32'd0);
        check("arst_in_ready",  32'(bus.in_ready),    32'd1);
        check("arst_afull",     32'(bus.almost_full), 32'd0);
        check("arst_ram_ena",   32'(bus.ram_ena),     32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        #2 reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
